// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the CPU port, VGA port and RAM-side bus of the two-port memory
// arbiter.
//   slave  : arbiter view (requests and mem_rdata in; acks, read returns,
//            RAM controls and wp_fault out)
//   master : environment view (CPU, VGA and RAM model)
// Signals:
//   cpu_req/cpu_we/cpu_adr/cpu_wdata  CPU request fields
//   cpu_ack/cpu_rvalid/cpu_rdata      CPU accept and read return
//   vga_req/vga_adr                   VGA read request
//   vga_ack/vga_rvalid/vga_rdata      VGA accept and read return
//   mem_en/mem_write/mem_read/mem_adr/mem_wdata  to the block RAM
//   mem_rdata                         from the block RAM
//   wp_fault                          sticky write-protect violation
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 13
);
    logic                     cpu_req;
    logic                     cpu_we;
    logic [RAM_ADDR_BITS-1:0] cpu_adr;
    logic [WIDTH-1:0]         cpu_wdata;
    logic                     cpu_ack;
    logic                     cpu_rvalid;
    logic [WIDTH-1:0]         cpu_rdata;

    logic                     vga_req;
    logic [RAM_ADDR_BITS-1:0] vga_adr;
    logic                     vga_ack;
    logic                     vga_rvalid;
    logic [WIDTH-1:0]         vga_rdata;

    logic                     mem_en;
    logic                     mem_write;
    logic                     mem_read;
    logic [RAM_ADDR_BITS-1:0] mem_adr;
    logic [WIDTH-1:0]         mem_wdata;
    logic [WIDTH-1:0]         mem_rdata;

    logic                     wp_fault;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata, vga_req, vga_adr, mem_rdata,
        output cpu_ack, cpu_rvalid, cpu_rdata, vga_ack, vga_rvalid, vga_rdata,
               mem_en, mem_write, mem_read, mem_adr, mem_wdata, wp_fault
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata, vga_req, vga_adr, mem_rdata,
        input  cpu_ack, cpu_rvalid, cpu_rdata, vga_ack, vga_rvalid, vga_rdata,
               mem_en, mem_write, mem_read, mem_adr, mem_wdata, wp_fault
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Merges a CPU load/store port and a VGA framebuffer read port onto a single
// negedge-clocked block RAM. VGA has fixed priority, but the CPU is granted
// after at most STARVE_MAX consecutive VGA grants while it waits.
// Pipeline: ack (comb, cycle c) -> RAM controls registered (c+1, RAM acts
// at the negedge) -> read data captured and rvalid asserted (c+2).
// Ports:
//   clk    system clock, all state on posedge
//   reset  asynchronous, active-high
//   bus    mem_arbiter_if.slave (CPU port, VGA port, RAM bus, wp_fault)
// Build option:
//   MEM_ARB_WP_EN  when defined, CPU writes below WP_LIMIT are acked but
//                  dropped, and wp_fault latches until reset. When undefined
//                  all writes pass through and wp_fault is tied 0.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 13,
    parameter int STARVE_MAX    = 4
`ifdef MEM_ARB_WP_EN
    ,
    parameter logic [RAM_ADDR_BITS-1:0] WP_LIMIT = 'h0400
`endif
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       cpu_gnt;
    logic       vga_gnt;
    logic       wp_block;
    logic       rd_vld_p1;
    logic       rd_cpu_p1;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == STARVE_LIM) ? v : v + 4'd1;
    endfunction

    // ---- stage p0: combinational grant ----
    // The CPU only wins a contested cycle once VGA has used up its run.
    always_comb begin
        vga_gnt = bus.vga_req && !(bus.cpu_req && (starve_cnt == STARVE_LIM));
        cpu_gnt = bus.cpu_req && !vga_gnt;
    end

    assign bus.cpu_ack = cpu_gnt;
    assign bus.vga_ack = vga_gnt;

`ifdef MEM_ARB_WP_EN
    assign wp_block = cpu_gnt && bus.cpu_we && (bus.cpu_adr < WP_LIMIT);
`else
    assign wp_block = 1'b0;
`endif

    // The count only measures an uninterrupted wait by the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (!bus.cpu_req || cpu_gnt) begin
            starve_cnt <= 4'd0;
        end else if (vga_gnt) begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // ---- stage p1: RAM controls, RAM samples them at the next negedge ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_en    <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_adr   <= '0;
            bus.mem_wdata <= '0;
            rd_vld_p1     <= 1'b0;
            rd_cpu_p1     <= 1'b0;
        end else begin
            bus.mem_en    <= (cpu_gnt || vga_gnt) && !wp_block;
            bus.mem_write <= cpu_gnt && bus.cpu_we && !wp_block;
            bus.mem_read  <= vga_gnt || (cpu_gnt && !bus.cpu_we);
            rd_vld_p1     <= vga_gnt || (cpu_gnt && !bus.cpu_we);
            rd_cpu_p1     <= cpu_gnt;
            // Address and write data hold when idle so the RAM bus stays quiet.
            if (vga_gnt) begin
                bus.mem_adr <= bus.vga_adr;
            end else if (cpu_gnt) begin
                bus.mem_adr   <= bus.cpu_adr;
                bus.mem_wdata <= bus.cpu_wdata;
            end
        end
    end

    // ---- stage p2: read data return to the tagged owner ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cpu_rvalid <= 1'b0;
            bus.vga_rvalid <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.vga_rdata  <= '0;
        end else begin
            bus.cpu_rvalid <= rd_vld_p1 && rd_cpu_p1;
            bus.vga_rvalid <= rd_vld_p1 && !rd_cpu_p1;
            if (rd_vld_p1 && rd_cpu_p1) begin
                bus.cpu_rdata <= bus.mem_rdata;
            end
            if (rd_vld_p1 && !rd_cpu_p1) begin
                bus.vga_rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_WP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wp_fault <= 1'b0;
        end else if (wp_block) begin
            bus.wp_fault <= 1'b1;
        end
    end
`else
    assign bus.wp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Bench for mem_arbiter: a negedge RAM model, a vector table for single
// accesses, hand-written multi-cycle sequences, and a randomized phase
// checked against a transaction-level model (shadow memory, return queue,
// starvation counter).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int W  = 16;
    localparam int A  = 13;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(W), .RAM_ADDR_BITS(A)) bus ();

    mem_arbiter #(.WIDTH(W), .RAM_ADDR_BITS(A), .STARVE_MAX(SM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Known pattern that unwritten RAM words return.
    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 7) ^ 16'hC3A5;
    endfunction

    // RAM model: acts on the negedge like the real block RAM.
    bit [15:0] ram    [0:8191];
    bit        ram_wr [0:8191];
    always @(negedge clk) begin
        if (bus.mem_en && bus.mem_write) begin
            ram[bus.mem_adr]    <= bus.mem_wdata;
            ram_wr[bus.mem_adr] <= 1'b1;
        end
        if (bus.mem_en && bus.mem_read)
            bus.mem_rdata <= ram_wr[bus.mem_adr] ? ram[bus.mem_adr] : init_val(int'(bus.mem_adr));
    end

    // Reference shadow memory for the random phase.
    bit [15:0] shm    [0:8191];
    bit        shm_wr [0:8191];
    function automatic logic [15:0] sh_rd(input logic [12:0] a);
        return shm_wr[a] ? shm[a] : init_val(int'(a));
    endfunction

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.vga_req   = 1'b0;
    endtask

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [12:0] cadr;
        logic [15:0] cwd;
        logic        vreq;
        logic [12:0] vadr;
        logic        cack;
        logic        vack;
        logic        en;
        logic        wr;
        logic        rd;
        logic [12:0] adr;
        logic [15:0] wd;
        logic        crv;
        logic        vrv;
        logic [15:0] rdata;
    } vec_t;

    typedef struct {
        int          due;
        bit          is_cpu;
        logic [15:0] data;
    } ret_t;

    vec_t tbl [6];
    ret_t q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ret_t r;
        logic e_c, e_v, c_acked, v_acked, x_crv, x_vrv;
        int st;

        tbl[0] = '{1'b1, 1'b0, 13'h0100, 16'h0000, 1'b0, 13'h0000,
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 13'h0100, 16'h0000, 1'b1, 1'b0, init_val('h100)};
        tbl[1] = '{1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 13'h1234,
                   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h1234, 16'h0000, 1'b0, 1'b1, init_val('h1234)};
        tbl[2] = '{1'b1, 1'b0, 13'h0200, 16'h0000, 1'b1, 13'h0300,
                   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h0300, 16'h0000, 1'b0, 1'b1, init_val('h300)};
        tbl[3] = '{1'b1, 1'b1, 13'h0900, 16'h5A5A, 1'b0, 13'h0000,
                   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 13'h0900, 16'h5A5A, 1'b0, 1'b0, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 13'h0910, 16'h1111, 1'b1, 13'h0400,
                   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h0400, 16'h0000, 1'b0, 1'b1, init_val('h400)};
        tbl[5] = '{1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 13'h0000,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};

        // ---- reset state ----
        idle();
        bus.cpu_adr = '0; bus.cpu_wdata = '0; bus.vga_adr = '0;
        reset = 1'b1;
        repeat (3) cyc();
        chk("rst cpu_ack",    32'(bus.cpu_ack),    32'(0));
        chk("rst vga_ack",    32'(bus.vga_ack),    32'(0));
        chk("rst cpu_rvalid", 32'(bus.cpu_rvalid), 32'(0));
        chk("rst vga_rvalid", 32'(bus.vga_rvalid), 32'(0));
        chk("rst cpu_rdata",  32'(bus.cpu_rdata),  32'(0));
        chk("rst vga_rdata",  32'(bus.vga_rdata),  32'(0));
        chk("rst mem_ctl",    32'({bus.mem_en, bus.mem_write, bus.mem_read}), 32'(0));
        chk("rst mem_adr",    32'(bus.mem_adr),    32'(0));
        chk("rst mem_wdata",  32'(bus.mem_wdata),  32'(0));
        chk("rst wp_fault",   32'(bus.wp_fault),   32'(0));
        reset = 1'b0;

        // ---- vector table: one access each, then two idle cycles ----
        for (int i = 0; i < 6; i++) begin
            cyc();
            bus.cpu_req = tbl[i].creq; bus.cpu_we = tbl[i].cwe;
            bus.cpu_adr = tbl[i].cadr; bus.cpu_wdata = tbl[i].cwd;
            bus.vga_req = tbl[i].vreq; bus.vga_adr = tbl[i].vadr;
            #1;
            chk($sformatf("tbl%0d cpu_ack", i), 32'(bus.cpu_ack), 32'(tbl[i].cack));
            chk($sformatf("tbl%0d vga_ack", i), 32'(bus.vga_ack), 32'(tbl[i].vack));
            cyc();
            idle();
            chk($sformatf("tbl%0d mem_ctl", i), 32'({bus.mem_en, bus.mem_write, bus.mem_read}),
                32'({tbl[i].en, tbl[i].wr, tbl[i].rd}));
            if (tbl[i].en) chk($sformatf("tbl%0d mem_adr", i), 32'(bus.mem_adr), 32'(tbl[i].adr));
            if (tbl[i].wr) chk($sformatf("tbl%0d mem_wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].wd));
            cyc();
            chk($sformatf("tbl%0d rvalids", i), 32'({bus.cpu_rvalid, bus.vga_rvalid}),
                32'({tbl[i].crv, tbl[i].vrv}));
            if (tbl[i].crv) chk($sformatf("tbl%0d cpu_rdata", i), 32'(bus.cpu_rdata), 32'(tbl[i].rdata));
            if (tbl[i].vrv) chk($sformatf("tbl%0d vga_rdata", i), 32'(bus.vga_rdata), 32'(tbl[i].rdata));
        end

        // ---- CPU write 16'hBEEF to 13'h0800 then read it back ----
        cyc();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_adr = 13'h0800; bus.cpu_wdata = 16'hBEEF;
        #1;
        chk("wr ack", 32'(bus.cpu_ack), 32'(1));
        cyc();
        bus.cpu_we = 1'b0;
        #1;
        chk("wr issue", 32'({bus.mem_en, bus.mem_write, bus.mem_read}), 32'(3'b110));
        chk("rd ack", 32'(bus.cpu_ack), 32'(1));
        cyc();
        idle();
        chk("rd issue", 32'({bus.mem_en, bus.mem_write, bus.mem_read}), 32'(3'b101));
        chk("rd early rvalid", 32'(bus.cpu_rvalid), 32'(0));
        cyc();
        chk("rd rvalid", 32'(bus.cpu_rvalid), 32'(1));
        chk("rd rdata", 32'(bus.cpu_rdata), 32'(16'hBEEF));
        cyc();
        chk("rd rvalid pulse", 32'(bus.cpu_rvalid), 32'(0));

        // ---- simultaneous requests ----
        cyc();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 13'h0010;
        bus.vga_req = 1'b1; bus.vga_adr = 13'h1000;
        #1;
        chk("sim acks c0", 32'({bus.cpu_ack, bus.vga_ack}), 32'(2'b01));
        cyc();
        bus.vga_req = 1'b0;
        #1;
        chk("sim acks c1", 32'({bus.cpu_ack, bus.vga_ack}), 32'(2'b10));
        cyc();
        idle();
        chk("sim rvalid c2", 32'({bus.cpu_rvalid, bus.vga_rvalid}), 32'(2'b01));
        chk("sim vga_rdata", 32'(bus.vga_rdata), 32'(init_val('h1000)));
        cyc();
        chk("sim rvalid c3", 32'({bus.cpu_rvalid, bus.vga_rvalid}), 32'(2'b10));
        chk("sim cpu_rdata", 32'(bus.cpu_rdata), 32'(init_val('h0010)));
        chk("sim vga_rdata hold", 32'(bus.vga_rdata), 32'(init_val('h1000)));

        // ---- starvation: both held, grants V V V V C V V V V C ----
        cyc();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 13'h0020;
        bus.vga_req = 1'b1; bus.vga_adr = 13'h1100;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("starve k%0d", k), 32'({bus.cpu_ack, bus.vga_ack}),
                (k % 5 == 4) ? 32'(2'b10) : 32'(2'b01));
            cyc();
        end
        idle();
        repeat (3) cyc();

        // ---- streaming: 8 back-to-back VGA reads ----
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                bus.vga_req = 1'b1; bus.vga_adr = 13'(13'h1000 + i);
            end else begin
                bus.vga_req = 1'b0;
            end
            #1;
            if (i < 8) chk($sformatf("stream ack%0d", i), 32'(bus.vga_ack), 32'(1));
            if (i >= 2) chk($sformatf("stream rvalid%0d", i), 32'(bus.vga_rvalid), (i < 10) ? 32'(1) : 32'(0));
            if (i >= 2 && i < 10) chk($sformatf("stream data%0d", i), 32'(bus.vga_rdata), 32'(init_val('h1000 + i - 2)));
            cyc();
        end

        // ---- reset pulse one cycle after vga_ack ----
        bus.vga_req = 1'b1; bus.vga_adr = 13'h1005;
        #1;
        chk("rstmid ack", 32'(bus.vga_ack), 32'(1));
        cyc();
        bus.vga_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstmid mem_ctl", 32'({bus.mem_en, bus.mem_write, bus.mem_read}), 32'(0));
        chk("rstmid mem_adr", 32'(bus.mem_adr), 32'(0));
        reset = 1'b0;
        cyc();
        chk("rstmid rvalid c2", 32'(bus.vga_rvalid), 32'(0));
        cyc();
        chk("rstmid rvalid c3", 32'(bus.vga_rvalid), 32'(0));

        // ---- write to low address 13'h0010 ----
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_adr = 13'h0010; bus.cpu_wdata = 16'h1234;
        #1;
        chk("wp ack", 32'(bus.cpu_ack), 32'(1));
        cyc();
        idle();
`ifdef MEM_ARB_WP_EN
        chk("wp issue", 32'({bus.mem_en, bus.mem_write}), 32'(0));
        chk("wp fault", 32'(bus.wp_fault), 32'(1));
`else
        chk("nowp issue", 32'({bus.mem_en, bus.mem_write}), 32'(2'b11));
        chk("nowp fault", 32'(bus.wp_fault), 32'(0));
`endif
        cyc();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 13'h0010;
        #1;
        chk("wp rd ack", 32'(bus.cpu_ack), 32'(1));
        cyc();
        idle();
        cyc();
        chk("wp rd rvalid", 32'(bus.cpu_rvalid), 32'(1));
`ifdef MEM_ARB_WP_EN
        chk("wp rd data", 32'(bus.cpu_rdata), 32'(init_val('h0010)));
        chk("wp fault sticky", 32'(bus.wp_fault), 32'(1));
`else
        chk("nowp rd data", 32'(bus.cpu_rdata), 32'(16'h1234));
`endif
        cyc();

        // ---- randomized traffic against the transaction model ----
        st = 0; c_acked = 1'b0; v_acked = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!bus.cpu_req || c_acked) begin
                bus.cpu_req   = ($urandom_range(0, 3) != 0);
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_adr   = 13'(13'h0A00 + $urandom_range(0, 31));
                bus.cpu_wdata = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                bus.cpu_req = 1'b0;
            end
            if (!bus.vga_req || v_acked) begin
                bus.vga_req = ($urandom_range(0, 2) != 0);
                bus.vga_adr = 13'(13'h0A00 + $urandom_range(0, 31));
            end
            #1;
            e_v = bus.vga_req && !(bus.cpu_req && st == SM);
            e_c = bus.cpu_req && !e_v;
            chk($sformatf("rnd%0d cpu_ack", n), 32'(bus.cpu_ack), 32'(e_c));
            chk($sformatf("rnd%0d vga_ack", n), 32'(bus.vga_ack), 32'(e_v));

            x_crv = 1'b0; x_vrv = 1'b0; r = '{0, 1'b0, 16'h0};
            if (q.size() > 0 && q[0].due == n) begin
                r = q.pop_front();
                x_crv = r.is_cpu;
                x_vrv = !r.is_cpu;
            end
            chk($sformatf("rnd%0d rvalids", n), 32'({bus.cpu_rvalid, bus.vga_rvalid}), 32'({x_crv, x_vrv}));
            if (x_crv) chk($sformatf("rnd%0d cpu_rdata", n), 32'(bus.cpu_rdata), 32'(r.data));
            if (x_vrv) chk($sformatf("rnd%0d vga_rdata", n), 32'(bus.vga_rdata), 32'(r.data));

            if (e_c && bus.cpu_we) begin
                shm[bus.cpu_adr]    = bus.cpu_wdata;
                shm_wr[bus.cpu_adr] = 1'b1;
            end else if (e_c) begin
                q.push_back('{n + 2, 1'b1, sh_rd(bus.cpu_adr)});
            end
            if (e_v) q.push_back('{n + 2, 1'b0, sh_rd(bus.vga_adr)});
            if (!bus.cpu_req || e_c) st = 0;
            else if (e_v && st < SM) st++;
            c_acked = e_c;
            v_acked = e_v;
            cyc();
        end
        idle();
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter directly upstream of the 16-bit block RAM.
- Merges a CPU load/store port and a VGA framebuffer read port onto the RAM's single en/memwrite/memread/adr/writedata interface, and returns memdata to whichever requester issued the read.
- The RAM acts on the negedge of clk, so the arbiter registers RAM controls at posedge and captures read data at the following posedge.
- VGA has fixed priority, with a bounded-starvation guarantee for the CPU.

Parameters:
WIDTH, 16, data width of RAM words and both ports
RAM_ADDR_BITS, 13, address width (8192 words)
STARVE_MAX, 4, max consecutive VGA grants while CPU is waiting; legal range 1..15
WP_LIMIT, 13'h0400, first writable address when MEM_ARB_WP_EN is defined

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; held with fields stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_adr  in  RAM_ADDR_BITS  CPU word address
cpu_wdata  in  WIDTH  CPU write data
cpu_ack  out  1  combinational; request accepted at the end of this cycle
cpu_rvalid  out  1  registered; cpu_rdata valid this cycle
cpu_rdata  out  WIDTH  CPU read data
vga_req  in  1  VGA read request; held until vga_ack
vga_adr  in  RAM_ADDR_BITS  VGA word address
vga_ack  out  1  combinational accept
vga_rvalid  out  1  registered; vga_rdata valid this cycle
vga_rdata  out  WIDTH  VGA read data
mem_en  out  1  to RAM en
mem_write  out  1  to RAM memwrite
mem_read  out  1  to RAM memread
mem_adr  out  RAM_ADDR_BITS  to RAM adr
mem_wdata  out  WIDTH  to RAM writedata
mem_rdata  in  WIDTH  from RAM memdata
wp_fault  out  1  sticky write-protect violation flag

Behaviour:
- Reset (async, active-high): all outputs 0, starvation counter 0, in-flight tags cleared. An access in flight when reset asserts produces no rvalid.
- Grant logic (combinational, current cycle):
  - If only one port requests, that port is acked.
  - If both request, VGA is acked unless starve_cnt == STARVE_MAX, in which case CPU is acked.
  - At most one ack per cycle.
- starve_cnt:
  - Increments on each VGA grant while cpu_req is high.
  - Clears on a CPU grant or whenever cpu_req is low.
  - Saturates at STARVE_MAX.
- Issue (posedge ending ack cycle c):
  - mem_en <= 1; mem_adr/mem_wdata <= granted fields.
  - mem_write <= cpu_we for a CPU grant, 0 for a VGA grant.
  - mem_read <= the inverse of mem_write.
  - Tag register records the owner of a read.
- With no grant, mem_en/mem_read/mem_write <= 0 and mem_adr/mem_wdata hold their last values.
- The RAM performs the access at the negedge inside cycle c+1.
- Return (posedge ending c+1): if the tag marks a read, the owner's rdata <= mem_rdata and its rvalid <= 1 for exactly one cycle (c+2). The other port's rdata holds.
- Latency: ack to rvalid = 2 cycles. Throughput: one access per cycle. Back-to-back reads from alternating ports return in grant order.
- Writes generate no rvalid.
- Deasserting req without ack is legal; no access is issued.
- Address width is passed through unmodified; no wrap or range check (except the optional feature).

Optional Feature:
- Macro: MEM_ARB_WP_EN.
- Defined:
  - A CPU write with cpu_adr < WP_LIMIT is still acked, but the issue cycle drives mem_en=0, mem_write=0.
  - wp_fault sets and stays set until reset.
  - Reads are unaffected.
- Undefined: wp_fault is tied 0 and all writes pass through.

Test Plan:
- Reset mid-read: assert reset one cycle after vga_ack -> vga_rvalid stays 0; all mem_* = 0.
- CPU write then read: CPU writes 16'hBEEF to 13'h0800, then reads 13'h0800 -> mem_write=1 in the issue cycle; cpu_rvalid exactly 2 cycles after the read's ack with cpu_rdata=16'hBEEF.
- Simultaneous requests: VGA reads 13'h1000, CPU reads 13'h0010 in the same cycle -> vga_ack first, cpu_ack the next cycle; vga_rvalid then cpu_rvalid on consecutive cycles with correct data.
- Starvation: vga_req held continuously with STARVE_MAX=4 and cpu_req high -> 4 VGA grants, then 1 CPU grant, then VGA resumes.
- Streaming: 8 back-to-back VGA reads from 13'h1000-13'h1007 -> 8 consecutive vga_rvalid cycles, data in address order.
- With MEM_ARB_WP_EN: CPU write 16'h1234 to 13'h0010 -> mem_en stays 0, wp_fault=1, subsequent read returns the original contents.
